// File: rtl/bus_region_decoder_pkg.sv
// bus_map_pkg: FSM state encoding and the default system memory map shared by the decoder and its users
package bus_map_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        BUSY   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [31:0] TEXT_BASE     = 32'h0000_0000;
    localparam logic [31:0] TEXT_MASK     = 32'hFFFF_8000;
    localparam logic [31:0] DATA_BASE     = 32'h0000_6000;
    localparam logic [31:0] DATA_MASK     = 32'hFFFF_E000;
    localparam logic [31:0] REGS_BASE     = 32'h1000_0000;
    localparam logic [31:0] REGS_MASK     = 32'hFFFF_F000;
    localparam logic [31:0] TEXTRAM_BASE  = 32'h1000_2000;
    localparam logic [31:0] TEXTRAM_MASK  = 32'hFFFF_E000;
    localparam logic [31:0] GRAPHRAM_BASE = 32'h1001_0000;
    localparam logic [31:0] GRAPHRAM_MASK = 32'hFFFF_0000;
    localparam logic [31:0] DMARAM_BASE   = 32'h1002_0000;
    localparam logic [31:0] DMARAM_MASK   = 32'hFFFF_FE00;
    localparam logic [31:0] BIOS_BASE     = 32'h1FC0_0000;
    localparam logic [31:0] BIOS_MASK     = 32'hFFC0_0000;

    // Slot 7 of the eight-window system map is parked on the top page, which no master uses
    localparam logic [31:0] SPARE_BASE    = 32'hFFFF_F000;
    localparam logic [31:0] SPARE_MASK    = 32'hFFFF_F000;

    // Packed eight-window map, region 0 in the low word (TEXT wins its overlap with DATA)
    localparam logic [8*32-1:0] SYS_BASE = {SPARE_BASE, BIOS_BASE, DMARAM_BASE, GRAPHRAM_BASE,
                                            TEXTRAM_BASE, REGS_BASE, DATA_BASE, TEXT_BASE};
    localparam logic [8*32-1:0] SYS_MASK = {SPARE_MASK, BIOS_MASK, DMARAM_MASK, GRAPHRAM_MASK,
                                            TEXTRAM_MASK, REGS_MASK, DATA_MASK, TEXT_MASK};

    // A wait field of all ones hands completion to the peripheral acknowledge
    localparam logic [3:0] WAIT_EXT = 4'hF;

endpackage

// File: rtl/bus_region_decoder_match.sv
// region_match: fixed-priority base/mask window match, lowest index wins
module region_match #(
    parameter int ADDR_W   = 32,
    parameter int N_REGION = 8,
    parameter logic [N_REGION*ADDR_W-1:0] BASE = '0,
    parameter logic [N_REGION*ADDR_W-1:0] MASK = '0
) (
    input  logic [ADDR_W-1:0]   addr,
    output logic [N_REGION-1:0] hit,
    output logic                miss
);

    // Scan from the top so a lower-index hit overwrites any higher one
    always_comb begin
        hit = '0;
        for (int i = N_REGION - 1; i >= 0; i--)
            if ((addr & MASK[i*ADDR_W +: ADDR_W]) == (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W])) begin
                hit = '0;
                hit[i] = 1'b1;
            end
    end

    assign miss = ~|hit;

endmodule

// File: rtl/bus_region_decoder.sv
// bus_region_decoder: registered region decode with wait states, ack/timeout and fault log; DECODE_PIPE_EN adds a decode pipeline stage
module bus_region_decoder
    import bus_map_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int N_REGION = 8,
    parameter logic [N_REGION*ADDR_W-1:0] REGION_BASE = {N_REGION{32'h0}},
    parameter logic [N_REGION*ADDR_W-1:0] REGION_MASK = {N_REGION{32'hFFFF_F000}},
    parameter int WAIT_W   = 4,
    parameter logic [N_REGION*WAIT_W-1:0] REGION_WAIT = {N_REGION{4'h0}},
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_we,
    output logic                req_done,
    output logic                req_err,
    output logic [N_REGION-1:0] region_sel,
    output logic                sel_we,
    input  logic [N_REGION-1:0] periph_ack,
    output logic                err_valid,
    output logic [ADDR_W-1:0]   err_addr,
    output logic                err_timeout,
    input  logic                err_clr
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t              state;
    logic [N_REGION-1:0] hit;
    logic [N_REGION-1:0] dec_hit;
    logic                miss;
    logic                dec_miss;
    logic                dec_go;
    logic                pipe_go;
    logic [WAIT_W-1:0]   wait_sel;
    logic [WAIT_W-1:0]   cnt;
    logic [TW-1:0]       tcnt;
    logic                ext;
    logic                ack_hit;
    logic                busy_end;
    logic                miss_fault;
    logic                to_fault;
    logic [ADDR_W-1:0]   acc_addr;

    region_match #(
        .ADDR_W   (ADDR_W),
        .N_REGION (N_REGION),
        .BASE     (REGION_BASE),
        .MASK     (REGION_MASK)
    ) u_match (
        .addr (req_addr),
        .hit  (hit),
        .miss (miss)
    );

`ifdef DECODE_PIPE_EN
    logic [N_REGION-1:0] hit_q;
    logic                miss_q;

    // Register the match result so the priority scan is cut from the FSM path
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            hit_q  <= hit;
            miss_q <= miss;
        end

    assign dec_hit  = hit_q;
    assign dec_miss = miss_q;
    assign dec_go   = state == DECODE;
    assign pipe_go  = req_valid;
`else
    assign dec_hit  = hit;
    assign dec_miss = miss;
    assign dec_go   = state == IDLE && req_valid;
    assign pipe_go  = 1'b0;
`endif

    // Wait count of the winning window; the hit vector is one-hot or zero
    always_comb begin
        wait_sel = '0;
        for (int i = 0; i < N_REGION; i++)
            wait_sel = wait_sel | (dec_hit[i] ? REGION_WAIT[i*WAIT_W +: WAIT_W] : '0);
    end

    assign ack_hit    = |(periph_ack & region_sel);
    assign busy_end   = ext ? (ack_hit || tcnt == T_LAST) : (cnt == '0);
    assign miss_fault = dec_go && dec_miss;
    assign to_fault   = state == BUSY && ext && !ack_hit && tcnt == T_LAST;

    // Access sequencer: accept, hold the select through the wait, pulse completion
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            region_sel <= '0;
            sel_we     <= 1'b0;
            req_done   <= 1'b0;
            req_err    <= 1'b0;
            cnt        <= '0;
            tcnt       <= '0;
            ext        <= 1'b0;
            acc_addr   <= '0;
        end else begin
            req_done <= 1'b0;
            req_err  <= 1'b0;
            case (state)
                IDLE, DECODE:
                    if (dec_go) begin
                        if (dec_miss) begin
                            state    <= DONE;
                            req_done <= 1'b1;
                            req_err  <= 1'b1;
                        end else begin
                            state      <= BUSY;
                            region_sel <= dec_hit;
                            sel_we     <= req_we;
                            cnt        <= wait_sel;
                            ext        <= &wait_sel;
                            tcnt       <= '0;
                            acc_addr   <= req_addr;
                        end
                    end else if (pipe_go) begin
                        state <= DECODE;
                    end
                BUSY:
                    if (busy_end) begin
                        state    <= DONE;
                        req_done <= 1'b1;
                        req_err  <= ext && !ack_hit;
                    end else begin
                        cnt  <= cnt - 1'b1;
                        tcnt <= tcnt + 1'b1;
                    end
                DONE: begin
                    state      <= IDLE;
                    region_sel <= '0;
                    sel_we     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end

    // Sticky fault log: first fault wins, a clear beats a simultaneous fault
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            err_valid   <= 1'b0;
            err_addr    <= '0;
            err_timeout <= 1'b0;
        end else if (err_clr) begin
            err_valid   <= 1'b0;
            err_addr    <= '0;
            err_timeout <= 1'b0;
        end else if ((miss_fault || to_fault) && !err_valid) begin
            err_valid   <= 1'b1;
            err_addr    <= miss_fault ? req_addr : acc_addr;
            err_timeout <= to_fault;
        end

endmodule
